// File: rtl/bytecode_fetcher.sv
// Bytecode fetcher: reads 1- or 2-byte instructions from program memory and issues them to a
// decoder with a start/ready handshake. Define BYTECODE_FETCHER_ACK_TIMEOUT_EN for the ack timeout.
module bytecode_fetcher #(
  parameter int unsigned ByteW      = 8,
  parameter int unsigned AddrW      = 16,
  parameter int unsigned AckTimeout = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               pc_load,
  input  logic [AddrW-1:0]   pc_value,
  output logic               mem_read,
  output logic [AddrW-1:0]   mem_addr,
  input  logic               mem_valid,
  input  logic [ByteW-1:0]   mem_data,
  output logic [2*ByteW-1:0] instruction_out,
  output logic               start,
  input  logic               ready,
  output logic [AddrW-1:0]   pc,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  if (AckTimeout == 0) begin : g_bad_timeout
    $error("AckTimeout must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StFetchOp,
    StFetchArg,
    StIssue,
    StWaitAck,
    StWaitDone,
    StHalt
  } state_e;

  localparam logic [ByteW-1:0] OpHaltA = ByteW'(8'hAC);
  localparam logic [ByteW-1:0] OpHaltB = ByteW'(8'hAF);

  state_e             state_q, state_d;
  logic [AddrW-1:0]   pc_q, pc_d;
  logic [ByteW-1:0]   op_q, op_d;
  logic [2*ByteW-1:0] instr_q, instr_d;
  logic               mem_two_byte;
  logic               issued_halt;

  assign mem_two_byte = mem_data inside {ByteW'(8'h10), ByteW'(8'h15), ByteW'(8'h16),
                                         ByteW'(8'h18), ByteW'(8'h19)};
  assign issued_halt  = instr_q[2*ByteW-1 -: ByteW] inside {OpHaltA, OpHaltB};

`ifdef BYTECODE_FETCHER_ACK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(AckTimeout + 1);

  logic [CntW-1:0] ack_cnt_q, ack_cnt_d;
  logic            error_q, error_d;

  // Counts WAIT_ACK cycles in which the decoder still reports idle.
  assign ack_cnt_d = (state_q == StWaitAck && ready) ? ack_cnt_q + CntW'(1) : '0;
  assign error     = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      ack_cnt_q <= ack_cnt_d;
      error_q   <= error_d;
    end
  end
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    instr_d  = instr_q;
    start    = 1'b0;
    mem_read = 1'b0;
`ifdef BYTECODE_FETCHER_ACK_TIMEOUT_EN
    error_d  = error_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pc_load) begin
          pc_d = pc_value;
        end else if (run) begin
          state_d = StFetchOp;
        end
      end
      StFetchOp: begin
        mem_read = 1'b1;
        if (mem_valid) begin
          pc_d = pc_q + AddrW'(1);
          op_d = mem_data;
          if (mem_two_byte) begin
            state_d = StFetchArg;
          end else begin
            instr_d = {mem_data, {ByteW{1'b0}}};
            state_d = StIssue;
          end
        end
      end
      StFetchArg: begin
        mem_read = 1'b1;
        if (mem_valid) begin
          pc_d    = pc_q + AddrW'(1);
          instr_d = {op_q, mem_data};
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (ready) begin
          // Suppressed while reset is asserted so a reset cycle never leaks a strobe.
          start   = ~reset;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (!ready) begin
          state_d = StWaitDone;
        end
`ifdef BYTECODE_FETCHER_ACK_TIMEOUT_EN
        else if (ack_cnt_q == CntW'(AckTimeout - 1)) begin
          error_d = 1'b1;
          state_d = StHalt;
        end
`endif
      end
      StWaitDone: begin
        if (ready) begin
          if (issued_halt) begin
            state_d = StHalt;
          end else if (run) begin
            state_d = StFetchOp;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHalt: begin
        if (pc_load) begin
          pc_d    = pc_value;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      op_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      instr_q <= instr_d;
    end
  end

  assign mem_addr        = pc_q;
  assign pc              = pc_q;
  assign instruction_out = instr_q;
  assign busy            = !(state_q inside {StIdle, StHalt});
  assign halted          = (state_q == StHalt);

endmodule

// File: tb/tb_bytecode_fetcher.sv
// Self-checking bench for bytecode_fetcher: directed scenarios plus a random program run
// against a memory/decoder model. Honors BYTECODE_FETCHER_ACK_TIMEOUT_EN when defined.
module tb_bytecode_fetcher;

  logic        clk;
  logic        reset;
  logic        run;
  logic        pc_load;
  logic [15:0] pc_value;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_data;
  logic [15:0] instruction_out;
  logic        start;
  logic        ready;
  logic [15:0] pc;
  logic        busy;
  logic        halted;
  logic        error;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          fixed_lat = 0;
  logic [15:0] model_pc;
  logic [7:0]  mem [0:65535];
  logic [7:0]  two_ops [5] = '{8'h10, 8'h15, 8'h16, 8'h18, 8'h19};

  bytecode_fetcher dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .pc_load         (pc_load),
    .pc_value        (pc_value),
    .mem_read        (mem_read),
    .mem_addr        (mem_addr),
    .mem_valid       (mem_valid),
    .mem_data        (mem_data),
    .instruction_out (instruction_out),
    .start           (start),
    .ready           (ready),
    .pc              (pc),
    .busy            (busy),
    .halted          (halted),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit is_two(input logic [7:0] op);
    return op inside {8'h10, 8'h15, 8'h16, 8'h18, 8'h19};
  endfunction

  // Program memory: answers after 1..3 cycles (or fixed_lat), injects stray mem_valid when idle.
  initial begin
    int          cnt;
    bit          pend;
    logic [15:0] hold;
    pend = 0; cnt = 0; hold = '0;
    mem_valid = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (!mem_read) begin
        pend = 0;
        if ($urandom_range(0, 7) == 0) begin
          mem_valid = 1'b1;
          mem_data  = 8'($urandom);
        end
      end else if (!pend) begin
        pend = 1;
        hold = mem_addr;
        cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
      end else begin
        check("mem_addr_stable", mem_addr, hold);
        cnt--;
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem[mem_addr];
          pend      = 0;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_mem_read"}, mem_read, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_instr"}, instruction_out, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_error"}, error, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; pc_load = 1'b0; ready = 1'b0;
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();
  endtask

  task automatic load_pc(input logic [15:0] a);
    run = 1'b0; pc_load = 1'b1; pc_value = a;
    tick();
    pc_load = 1'b0;
    check("load_pc", pc, a);
    check("load_halted", halted, 0);
    check("load_busy", busy, 0);
    model_pc = a;
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (!(busy && !mem_read) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_reach_issue"}, n < 100, 1);
  endtask

  // One full instruction: fetch, stall in ISSUE, handshake, optional run drop in WAIT_DONE.
  task automatic do_instr(input int stall, input int ack_lat, input int done_lat,
                          input bit drop_run);
    logic [7:0]  op, arg;
    logic [15:0] a1, npc;
    bit          two, hlt;
    op  = mem[model_pc];
    two = is_two(op);
    a1  = model_pc + 16'd1;
    arg = two ? mem[a1] : 8'h00;
    npc = model_pc + (two ? 16'd2 : 16'd1);
    hlt = (op == 8'hAC) || (op == 8'hAF);
    run = 1'b1; ready = 1'b0;
    wait_issue("instr");
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        pc_load = 1'b1;
        pc_value = 16'($urandom);
      end
      #1 check("no_start_in_stall", start, 0);
      tick();
      pc_load = 1'b0;
    end
    check("pc_load_ignored", pc, npc);
    ready = 1'b1;
    #1;
    check("start", start, 1);
    check("instr", instruction_out, {op, arg});
    tick();
    check("start_one_cycle", start, 0);
    repeat (ack_lat) tick();
    ready = 1'b0;
    tick();
    if (drop_run) run = 1'b0;
    repeat (done_lat) tick();
    check("busy_wait_done", busy, 1);
    ready = 1'b1;
    tick();
    check("instr_held", instruction_out, {op, arg});
    check("pc_after", pc, npc);
    if (hlt) begin
      check("halted", halted, 1);
      check("halt_busy", busy, 0);
    end else if (!drop_run) begin
      check("refetch_read", mem_read, 1);
      check("refetch_addr", mem_addr, npc);
    end else begin
      check("idle_busy", busy, 0);
      check("idle_halted", halted, 0);
      check("idle_read", mem_read, 0);
    end
    model_pc = npc;
  endtask

  initial begin
    logic [15:0] base, a;
    logic [7:0]  op;
    int          r;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h60;
    reset = 1'b1; run = 1'b0; pc_load = 1'b0; pc_value = '0; ready = 1'b0;
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    // Single-byte opcode at 0, ready toggles, then continues fetching.
    model_pc = 16'h0000;
    do_instr(0, 0, 0, 0);
    // Issue stalled 5 cycles, run dropped during WAIT_DONE.
    do_instr(5, 1, 2, 1);

    // Two-byte opcode with slow memory.
    mem[16'h0004] = 8'h18;
    mem[16'h0005] = 8'h05;
    fixed_lat = 3;
    load_pc(16'h0004);
    do_instr(0, 0, 0, 1);
    check("two_byte_pc", pc, 16'h0006);
    fixed_lat = 0;

    // Halting opcode at the top of memory wraps pc.
    mem[16'hFFFF] = 8'hAF;
    load_pc(16'hFFFF);
    do_instr(0, 1, 0, 0);
    check("wrap_pc", pc, 16'h0000);
    load_pc(16'h0300);

    // pc_load beats run in IDLE; run takes effect one cycle later.
    pc_load = 1'b1; pc_value = 16'h0400; run = 1'b1;
    tick();
    check("prio_pc", pc, 16'h0400);
    check("prio_no_read", mem_read, 0);
    pc_load = 1'b0;
    tick();
    check("prio_read", mem_read, 1);
    check("prio_addr", mem_addr, 16'h0400);
    model_pc = 16'h0400;
    do_instr(1, 1, 1, 1);

    // Random program.
    base = 16'($urandom);
    a = base;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 8) op = two_ops[r % 5];
      else if (r == 19) op = ($urandom_range(0, 1) == 0) ? 8'hAC : 8'hAF;
      else begin
        op = 8'($urandom);
        if (is_two(op) || op == 8'hAC || op == 8'hAF) op = 8'h60;
      end
      mem[a] = op;
      a = a + 16'd1;
      if (is_two(op)) begin
        mem[a] = 8'($urandom);
        a = a + 16'd1;
      end
    end
    load_pc(base);
    for (int i = 0; i < 40; i++) begin
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0));
      if (halted) load_pc(model_pc);
    end

    // Reset in the middle of a fetch.
    do_reset();
    fixed_lat = 3;
    load_pc(16'h0200);
    run = 1'b1;
    tick();
    tick();
    check("midfetch_read", mem_read, 1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_fetch");
    reset = 1'b0; run = 1'b0;
    fixed_lat = 0;
    tick();

    // Reset while in ISSUE with ready rising: no start strobe.
    load_pc(16'h0100);
    run = 1'b1; ready = 1'b0;
    wait_issue("rst_issue");
    reset = 1'b1; ready = 1'b1;
    #1 check("rst_no_start", start, 0);
    tick();
    check_reset_vals("rst_issue");
    reset = 1'b0; ready = 1'b0; run = 1'b0;
    tick();

    // Reset during WAIT_ACK.
    load_pc(16'h0100);
    run = 1'b1; ready = 1'b0;
    wait_issue("rst_ack");
    ready = 1'b1;
    #1 check("ack_start", start, 1);
    repeat (3) tick();
    check("ack_busy", busy, 1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_ack");
    reset = 1'b0; ready = 1'b0; run = 1'b0;
    tick();

    // Decoder that never drops ready after start.
    load_pc(16'h0100);
    run = 1'b1; ready = 1'b0;
    wait_issue("timeout");
    ready = 1'b1;
    #1 check("to_start", start, 1);
`ifdef BYTECODE_FETCHER_ACK_TIMEOUT_EN
    repeat (16) tick();
    check("to_not_yet", halted, 0);
    check("to_not_yet_err", error, 0);
    tick();
    check("to_halted", halted, 1);
    check("to_error", error, 1);
    check("to_busy", busy, 0);
    pc_load = 1'b1; pc_value = 16'h0100;
    tick();
    pc_load = 1'b0;
    check("to_error_sticky", error, 1);
    do_reset();
    check("to_error_cleared", error, 0);
`else
    repeat (20) tick();
    check("no_to_busy", busy, 1);
    check("no_to_halted", halted, 0);
    check("no_to_error", error, 0);
    check("no_to_start", start, 0);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
